// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: word type, op codes, FSM states.
// Op decode helpers are used by muldiv_unit (divider enabled via MULDIV_DIV_EN).
package muldiv_unit_pkg;

    localparam int unsigned XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring divide step
// when MULDIV_DIV_EN is defined. hi/lo form the double-width working register.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             qbit;

    // Partial remainder stays below the divisor, so it always fits in WIDTH bits.
    always_comb begin
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd_i};
        qbit    = ~diff[WIDTH+1];
        if (is_div_i) begin
            hi_o = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], qbit};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div_i;

    always_comb begin
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M multiply/divide unit: IDLE/CALC/DONE FSM, counter, sign handling.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 finish at once with 0.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    muldiv_state_t    state_q;
    logic [CW-1:0]    cnt_q;
    muldiv_op_t       op_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q, result_q;

    logic             a_neg, b_neg, neg_d, special;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;
    logic [WIDTH-1:0] step_hi, step_lo, fin_res;
    logic [2*WIDTH-1:0] prod_s;

    always_comb begin
        a_neg       = op_a_signed(op) & arg1[WIDTH-1];
        b_neg       = op_b_signed(op) & arg2[WIDTH-1];
        a_mag       = a_neg ? -arg1 : arg1;
        b_mag       = b_neg ? -arg2 : arg2;
        neg_d       = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_res = '0;
`ifdef MULDIV_DIV_EN
        // Divide by zero and signed overflow bypass the iterative datapath.
        if (op_is_div(op)) begin
            if (arg2 == '0) begin
                special     = 1'b1;
                special_res = op[1] ? arg1 : '1;
            end else if (op_a_signed(op) && arg1 == {1'b1, {(WIDTH-1){1'b0}}}
                         && arg2 == '1) begin
                special     = 1'b1;
                special_res = op[1] ? '0 : arg1;
            end
        end
`else
        if (op_is_div(op)) begin
            special = 1'b1;
        end
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        prod_s  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin_res = '0;
        if (!op_q[2]) begin
            fin_res = (op_q == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
`ifdef MULDIV_DIV_EN
        else if (op_q[1]) begin
            fin_res = neg_q ? -step_hi : step_hi;
        end else begin
            fin_res = neg_q ? -step_lo : step_lo;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= neg_d;
                        hi_q   <= '0;
                        lo_q   <= a_mag;
                        opnd_q <= b_mag;
                        if (special) begin
                            result_q <= special_res;
                            cnt_q    <= '0;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q   <= CW'(WIDTH);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= fin_res;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int unsigned W = 32;

    logic       clock = 1'b0;
    logic       reset, stall, flush, start;
    muldiv_op_t op;
    word_t      arg1, arg2, result;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        muldiv_op_t o;
        word_t      a;
        word_t      b;
        word_t      exp;
        int         cyc;
    } vec_t;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .stall  (stall),
        .flush  (flush),
        .start  (start),
        .op     (op),
        .arg1   (arg1),
        .arg2   (arg2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Launch one op in cycle 0 and observe cycles 1..60.
    task automatic run_op(input muldiv_op_t o, input word_t a, input word_t b,
                          output int first_done, output int n_done,
                          output int n_busy, output word_t res);
        first_done = -1;
        n_done     = 0;
        n_busy     = 0;
        res        = '0;
        @(posedge clock); #1;
        op = o; arg1 = a; arg2 = b; start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    res        = result;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; start = 1'b0;
        op = OP_MUL; arg1 = '0; arg2 = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int fd, nd, nb;
        word_t r;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, fd, nd, nb, r);
        checks++;
        if (fd !== 33 || nd !== 1) begin
            failures++;
            $display("FAIL mul_timing first_done=%0d n_done=%0d expected 33/1", fd, nd);
        end
        checks++;
        if (nb !== 33) begin
            failures++;
            $display("FAIL mul_busy busy_cycles=%0d expected 33", nb);
        end
        checks++;
        if (r !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mul_7x-3 result=%h expected ffffffeb", r);
        end
        run_op(OP_MUL, 32'd6, 32'd7, fd, nd, nb, r);
        checks++;
        if (r !== 32'd42 || fd !== 33) begin
            failures++;
            $display("FAIL mul_6x7 result=%h cycle=%0d expected 2a at 33", r, fd);
        end
    endtask

    task automatic test_mulh();
        vec_t tbl[4];
        int fd, nd, nb;
        word_t r;
        tbl[0] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        tbl[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[2] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
        tbl[3] = '{OP_MULH,   32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 33};
        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].o, tbl[i].a, tbl[i].b, fd, nd, nb, r);
            checks++;
            if (r !== tbl[i].exp || fd !== tbl[i].cyc) begin
                failures++;
                $display("FAIL mulh_vec%0d result=%h cycle=%0d expected %h at %0d",
                         i, r, fd, tbl[i].exp, tbl[i].cyc);
            end
        end
    endtask

    task automatic test_div();
        int fd, nd, nb;
        word_t r;
`ifdef MULDIV_DIV_EN
        vec_t tbl[11];
        tbl[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        tbl[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        tbl[2]  = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        tbl[3]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        tbl[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[5]  = '{OP_REMU, 32'd5,         32'd0,         32'd5,         1};
        tbl[6]  = '{OP_DIVU, 32'd100,       32'd7,         32'd14,        33};
        tbl[7]  = '{OP_REMU, 32'd100,       32'd7,         32'd2,         33};
        tbl[8]  = '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        tbl[9]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        tbl[10] = '{OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 33};
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].o, tbl[i].a, tbl[i].b, fd, nd, nb, r);
            checks++;
            if (r !== tbl[i].exp || fd !== tbl[i].cyc || nd !== 1) begin
                failures++;
                $display("FAIL div_vec%0d result=%h cycle=%0d n_done=%0d expected %h at %0d",
                         i, r, fd, nd, tbl[i].exp, tbl[i].cyc);
            end
        end
`else
        run_op(OP_DIV, 32'd10, 32'd2, fd, nd, nb, r);
        checks++;
        if (r !== '0 || fd !== 1 || nb !== 1) begin
            failures++;
            $display("FAIL nodiv_div result=%h cycle=%0d busy_cycles=%0d expected 0 at 1 busy 1",
                     r, fd, nb);
        end
        run_op(OP_REMU, 32'd9, 32'd4, fd, nd, nb, r);
        checks++;
        if (r !== '0 || fd !== 1 || nd !== 1) begin
            failures++;
            $display("FAIL nodiv_remu result=%h cycle=%0d n_done=%0d expected 0 at 1", r, fd, nd);
        end
`endif
    endtask

    task automatic test_stall();
        int fd = -1;
        word_t r = '0;
        @(posedge clock); #1;
        op = OP_MUL; arg1 = 32'd3; arg2 = 32'd4; start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            stall = ((c >= 5 && c <= 9) || (c >= 38 && c <= 40));
            if (done && fd < 0) begin
                fd = c;
                r  = result;
            end
            if (c == 40) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold_done done=%b expected 1", done);
                end
            end
            if (c == 42) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_release done=%b busy=%b expected 0/0", done, busy);
                end
            end
        end
        stall = 1'b0;
        checks++;
        if (fd !== 38 || r !== 32'd12) begin
            failures++;
            $display("FAIL stall_mul first_done=%0d result=%h expected 38/0000000c", fd, r);
        end
    endtask

    task automatic test_flush();
        int fd, nd, nb;
        word_t r;
        run_op(OP_MUL, 32'd6, 32'd7, fd, nd, nb, r);
        nd = 0;
        @(posedge clock); #1;
`ifdef MULDIV_DIV_EN
        op = OP_DIVU; arg1 = 32'd100; arg2 = 32'd7;
`else
        op = OP_MUL; arg1 = 32'd9; arg2 = 32'd9;
`endif
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            flush = (c == 10);
            if (done) nd++;
            if (c == 11) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_idle busy=%b expected 0", busy);
                end
            end
        end
        flush = 1'b0;
        checks++;
        if (nd !== 0 || result !== 32'd42) begin
            failures++;
            $display("FAIL flush_abort n_done=%0d result=%h expected 0/0000002a", nd, result);
        end
        @(posedge clock); #1;
        op = OP_MUL; arg1 = 32'd2; arg2 = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_start busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        @(posedge clock); #1;
        op = OP_MUL; arg1 = 32'd9; arg2 = 32'd9; start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            reset = (c == 10);
            if (done) nd++;
            if (c == 11) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
                    failures++;
                    $display("FAIL reset_mid busy=%b done=%b result=%h expected 0/0/0",
                             busy, done, result);
                end
            end
        end
        reset = 1'b0;
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done n_done=%0d expected 0", nd);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        word_t r1 = '0, r2 = '0;
        @(posedge clock); #1;
        op = OP_MUL; arg1 = 32'd3; arg2 = 32'd4; start = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clock); #1;
            arg1 = 32'd5; arg2 = 32'd5;
            start = (c <= 34);
            if (done) begin
                if (d1 < 0) begin
                    d1 = c; r1 = result;
                end else if (d2 < 0) begin
                    d2 = c; r2 = result;
                end
            end
            if (c == 34) begin
                checks++;
                if (busy !== 1'b0 || result !== 32'd12) begin
                    failures++;
                    $display("FAIL b2b_gap busy=%b result=%h expected 0/0000000c", busy, result);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (d1 !== 33 || r1 !== 32'd12) begin
            failures++;
            $display("FAIL b2b_first cycle=%0d result=%h expected 33/0000000c", d1, r1);
        end
        checks++;
        if (d2 !== 67 || r2 !== 32'd25) begin
            failures++;
            $display("FAIL b2b_second cycle=%0d result=%h expected 67/00000019", d2, r2);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
